// File: rtl/dmem_arbiter.sv
// Round-robin owner arbiter for the shared single-port data memory; grant one cycle after req.
// One beat per cycle, bursts capped at BURST_MAX; a waiting master simply sees ack low.
module dmem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              last0,
   input  logic              last1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [1:0]        owner,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

   localparam logic [3:0] BEAT_LIMIT = 4'(BURST_MAX);

   state_t     state, state_nxt;
   logic       rr_ptr, rr_ptr_nxt;
   logic [3:0] beat_cnt, beat_cnt_nxt;
   logic       cur_req, cur_last, oth_req, rel;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rr_ptr   <= 1'b0;
         beat_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      beat_cnt_nxt = beat_cnt;
      ack0         = 1'b0;
      ack1         = 1'b0;
      rdata0       = '0;
      rdata1       = '0;
      mem_we       = 1'b0;
      mem_a        = '0;
      mem_wd       = '0;

      cur_req  = (state == GNT1) ? req1  : req0;
      cur_last = (state == GNT1) ? last1 : last0;
      oth_req  = (state == GNT1) ? req0  : req1;
      // A dropped req releases without a beat, so last/cap only matter when req is up.
      rel      = !cur_req || cur_last || ((beat_cnt + 4'd1) == BEAT_LIMIT);

      if (state == GNT0 && req0) begin
         ack0   = 1'b1;
         rdata0 = mem_rd;
         mem_we = we0;
         mem_a  = addr0;
         mem_wd = wdata0;
      end
      if (state == GNT1 && req1) begin
         ack1   = 1'b1;
         rdata1 = mem_rd;
         mem_we = we1;
         mem_a  = addr1;
         mem_wd = wdata1;
      end

      if (state == IDLE) begin
         if (req0 && req1)
            state_nxt = rr_ptr ? GNT1 : GNT0;
         else if (req0)
            state_nxt = GNT0;
         else if (req1)
            state_nxt = GNT1;
      end else if (rel) begin
         rr_ptr_nxt   = (state == GNT0);
         beat_cnt_nxt = 4'd0;
         if (oth_req)
            state_nxt = (state == GNT0) ? GNT1 : GNT0;
         else if (cur_req)
            state_nxt = state;
         else
            state_nxt = IDLE;
      end else begin
         beat_cnt_nxt = beat_cnt + 4'd1;
      end
   end

   assign owner = state;
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: bench-side memory, queued masters and an owner-level reference model.
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0, req1, we0, we1, last0, last1;
   logic [AW-1:0] addr0, addr1, mem_a;
   logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wd, mem_rd;
   logic          ack0, ack1, mem_we, busy;
   logic [1:0]    owner;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1), .mem_we(mem_we), .mem_a(mem_a),
      .mem_wd(mem_wd), .mem_rd(mem_rd), .owner(owner), .busy(busy)
   );

   // memory seen by the DUT, and the memory the model expects
   logic [DW-1:0] tmem [32];
   logic [DW-1:0] rmem [32];
   assign mem_rd = tmem[mem_a[4:0]];
   always @(posedge clk) if (mem_we) tmem[mem_a[4:0]] <= mem_wd;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   bit    en0, en1;

   int checks = 0;
   int failures = 0;

   // model state: m_own 0 = nobody, 1 = core, 2 = loader
   int            m_own, m_cnt, m_pref, m_idx;
   bit            m_acc;
   logic          mrq [2];
   logic          mw  [2];
   logic          ml  [2];
   logic [AW-1:0] ma  [2];
   logic [DW-1:0] md  [2];

   logic          s_ack0, s_ack1, s_we, s_busy;
   logic [1:0]    s_own;
   logic [DW-1:0] s_rd0;

   function automatic beat_t mk(input logic w, input int a, input logic [DW-1:0] d, input logic l);
      beat_t b;
      b.we = w; b.addr = AW'(a); b.data = d; b.last = l;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      beat_t b;
      if (en0 && q0.size() > 0) begin
         b = q0[0];
         req0 = 1'b1; we0 = b.we; addr0 = b.addr; wdata0 = b.data; last0 = b.last;
      end else begin
         req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; last0 = 1'b0;
      end
      if (en1 && q1.size() > 0) begin
         b = q1[0];
         req1 = 1'b1; we1 = b.we; addr1 = b.addr; wdata1 = b.data; last1 = b.last;
      end else begin
         req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; last1 = 1'b0;
      end
   endtask

   task automatic eval_cmp();
      logic          e_ack [2];
      logic [DW-1:0] e_rd  [2];
      logic          e_we;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_wd;
      int            e_own;
      mrq[0] = req0; mw[0] = we0; ma[0] = addr0; md[0] = wdata0; ml[0] = last0;
      mrq[1] = req1; mw[1] = we1; ma[1] = addr1; md[1] = wdata1; ml[1] = last1;
      e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
      e_we = 1'b0; e_a = '0; e_wd = '0;
      e_own = rst ? m_own : 0;
      m_acc = 1'b0;
      m_idx = 0;
      if (e_own != 0) begin
         m_idx = e_own - 1;
         m_acc = mrq[m_idx];
      end
      if (m_acc) begin
         e_ack[m_idx] = 1'b1;
         e_rd[m_idx]  = rmem[ma[m_idx][4:0]];
         e_we = mw[m_idx];
         e_a  = ma[m_idx];
         e_wd = md[m_idx];
      end
      chk("ack0",   32'(ack0),   32'(e_ack[0]));
      chk("ack1",   32'(ack1),   32'(e_ack[1]));
      chk("rdata0", rdata0,      e_rd[0]);
      chk("rdata1", rdata1,      e_rd[1]);
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_a",  mem_a,       e_a);
      chk("mem_wd", mem_wd,      e_wd);
      chk("owner",  32'(owner),  32'(e_own));
      chk("busy",   32'(busy),   32'(e_own != 0));
      s_ack0 = ack0; s_ack1 = ack1; s_we = mem_we; s_busy = busy; s_own = owner; s_rd0 = rdata0;
   endtask

   task automatic advance();
      int oth;
      if (s_ack0 && q0.size() > 0) void'(q0.pop_front());
      if (s_ack1 && q1.size() > 0) void'(q1.pop_front());
      if (!rst) begin
         m_own = 0; m_cnt = 0; m_pref = 0;
      end else if (m_own == 0) begin
         if (mrq[0] && mrq[1]) m_own = m_pref + 1;
         else if (mrq[0])      m_own = 1;
         else if (mrq[1])      m_own = 2;
      end else begin
         oth = 1 - m_idx;
         if (m_acc && mw[m_idx]) rmem[ma[m_idx][4:0]] = md[m_idx];
         if (!mrq[m_idx] || ml[m_idx] || (m_cnt + 1 == BM)) begin
            m_pref = oth;
            m_cnt  = 0;
            if (mrq[oth])        m_own = oth + 1;
            else if (mrq[m_idx]) m_own = m_idx + 1;
            else                 m_own = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      eval_cmp();
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic run_until_idle(input int maxc, input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while ((q0.size() > 0 || q1.size() > 0 || s_own != 2'b00) && n < maxc);
      checks++;
      if (q0.size() > 0 || q1.size() > 0 || s_own != 2'b00) begin
         failures++;
         $display("FAIL timeout_%s actual=busy after %0d cycles required=idle", name, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int pref_before, idle_bad, w0, w1, mw0, mw1, r0, r1, mr0, mr1, acks1, n;
      for (int i = 0; i < 32; i++) begin
         tmem[i] = DW'(i);
         rmem[i] = DW'(i);
      end
      en0 = 1'b1; en1 = 1'b1;
      m_own = 0; m_cnt = 0; m_pref = 0;
      drive();
      #2;
      chk("rst_ack0",   32'(ack0),   32'd0);
      chk("rst_ack1",   32'(ack1),   32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_owner",  32'(owner),  32'd0);
      chk("rst_busy",   32'(busy),   32'd0);
      step();
      step();
      rst = 1'b1;

      // contention: both masters start together, core wins first
      q0.push_back(mk(1'b1, 1, 32'h11, 1'b0));
      q0.push_back(mk(1'b1, 2, 32'h12, 1'b1));
      q1.push_back(mk(1'b1, 3, 32'h21, 1'b0));
      q1.push_back(mk(1'b1, 4, 32'h22, 1'b1));
      step(); chk("cont_c1_owner", 32'(s_own), 32'd0);
      step(); chk("cont_c2_owner", 32'(s_own), 32'd1); chk("cont_c2_ack0", 32'(s_ack0), 32'd1);
      step(); chk("cont_c3_owner", 32'(s_own), 32'd1);
      step(); chk("cont_c4_owner", 32'(s_own), 32'd2); chk("cont_c4_ack1", 32'(s_ack1), 32'd1);
      step(); chk("cont_c5_owner", 32'(s_own), 32'd2);
      run_until_idle(20, "cont");
      chk("cont_mem1", tmem[1], 32'h11);
      chk("cont_mem2", tmem[2], 32'h12);
      chk("cont_mem3", tmem[3], 32'h21);
      chk("cont_mem4", tmem[4], 32'h22);

      // single read of word 5
      q0.push_back(mk(1'b0, 5, 32'h0, 1'b1));
      step(); chk("sr_c1_ack0", 32'(s_ack0), 32'd0);
      step(); chk("sr_c2_ack0", 32'(s_ack0), 32'd1); chk("sr_c2_rdata0", s_rd0, 32'd5);
      step();
      step(); chk("sr_c4_owner", 32'(s_own), 32'd0);

      // request drop mid-burst hands over to the loader
      en1 = 1'b0;
      q0.push_back(mk(1'b1, 24, 32'hA24, 1'b0));
      q0.push_back(mk(1'b1, 25, 32'hA25, 1'b0));
      q0.push_back(mk(1'b1, 26, 32'hA26, 1'b1));
      q1.push_back(mk(1'b1, 27, 32'hA27, 1'b1));
      step();
      step(); chk("drop_c2_ack0", 32'(s_ack0), 32'd1);
      en0 = 1'b0; en1 = 1'b1;
      step(); chk("drop_c3_ack0", 32'(s_ack0), 32'd0); chk("drop_c3_we", 32'(s_we), 32'd0);
      step(); chk("drop_c4_owner", 32'(s_own), 32'd2); chk("drop_c4_ack1", 32'(s_ack1), 32'd1);
      q0.delete(); en0 = 1'b1;
      run_until_idle(20, "drop");
      chk("drop_mem24", tmem[24], 32'hA24);
      chk("drop_mem25", tmem[25], 32'd25);
      chk("drop_mem27", tmem[27], 32'hA27);

      // burst cap: long loader burst against a continuously requesting core
      for (int i = 0; i < 10; i++) q1.push_back(mk(1'b1, 8 + i, 32'hB00 + i, i == 9));
      for (int i = 0; i < 12; i++) q0.push_back(mk(1'b0, i, 32'h0, i == 11));
      w0 = 0; w1 = 0; mw0 = 0; mw1 = 0; r0 = 0; r1 = 0; mr0 = 0; mr1 = 0; acks1 = 0; n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
         step();
         n++;
         w0 = (req0 && s_own == 2'b10) ? w0 + 1 : 0;
         w1 = (req1 && s_own == 2'b01) ? w1 + 1 : 0;
         r0 = s_ack0 ? r0 + 1 : 0;
         r1 = s_ack1 ? r1 + 1 : 0;
         if (s_ack1) acks1++;
         if (w0 > mw0) mw0 = w0;
         if (w1 > mw1) mw1 = w1;
         if (r0 > mr0) mr0 = r0;
         if (r1 > mr1) mr1 = r1;
      end
      chk("cap_run0",     32'(mr0), 32'd4);
      chk("cap_run1",     32'(mr1), 32'd4);
      chk("cap_wait0_ok", 32'(mw0 <= 4), 32'd1);
      chk("cap_wait1_ok", 32'(mw1 <= 4), 32'd1);
      chk("cap_acks1",    32'(acks1), 32'd10);
      run_until_idle(20, "cap");
      chk("cap_mem17", tmem[17], 32'hB09);

      // idle stretch leaves the round-robin pointer alone
      pref_before = m_pref;
      idle_bad = 0;
      repeat (20) begin
         step();
         if (s_we || s_busy) idle_bad++;
      end
      chk("idle_activity", 32'(idle_bad), 32'd0);
      q0.push_back(mk(1'b0, 6, 32'h0, 1'b1));
      q1.push_back(mk(1'b0, 7, 32'h0, 1'b1));
      step();
      step(); chk("idle_rr_owner", 32'(s_own), 32'(pref_before + 1));
      run_until_idle(20, "rr");

      // reset in the middle of a loader write burst
      q1.push_back(mk(1'b1, 18, 32'hC18, 1'b0));
      q1.push_back(mk(1'b1, 19, 32'hC19, 1'b0));
      q1.push_back(mk(1'b1, 20, 32'hC20, 1'b1));
      step();
      step(); chk("mrst_c2_ack1", 32'(s_ack1), 32'd1);
      drive();
      #1 rst = 1'b0;
      #1;
      chk("mrst_mem_we", 32'(mem_we), 32'd0);
      chk("mrst_owner",  32'(owner),  32'd0);
      chk("mrst_ack1",   32'(ack1),   32'd0);
      @(negedge clk);
      eval_cmp();
      @(posedge clk);
      advance();
      #1;
      q0.delete(); q1.delete();
      step();
      rst = 1'b1;
      step();
      chk("mrst_mem18", tmem[18], 32'hC18);
      chk("mrst_mem19", tmem[19], 32'd19);
      q0.push_back(mk(1'b0, 9, 32'h0, 1'b1));
      q1.push_back(mk(1'b0, 10, 32'h0, 1'b1));
      step();
      step(); chk("mrst_first_owner", 32'(s_own), 32'd1);
      run_until_idle(20, "post_rst");

      for (int i = 0; i < 32; i++) chk("final_mem", tmem[i], rmem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port 32-word data memory between the CPU core (requester 0) and the debug/DMA loader (requester 1). It sits between both masters and the data memory's `WE`/`A`/`WD`/`RD` pins. It grants the memory to one owner at a time, with round-robin fairness and bounded bursts. It also steers read data and acknowledges back to the owner.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, address width; passed through unmodified
- `BURST_MAX`, 4, maximum beats per grant (1..15)

- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `req0`/`req1` in 1: requester wants the memory, held until `last` beat acked
- `we0`/`we1` in 1: beat is a write when 1
- `addr0`/`addr1` in `ADDR_W`: beat address
- `wdata0`/`wdata1` in `DATA_W`: write data
- `last0`/`last1` in 1: current beat is the final beat of the burst
- `ack0`/`ack1` out 1: beat accepted this cycle
- `rdata0`/`rdata1` out `DATA_W`: read data, valid when `ack` is 1 and `we` is 0
- `mem_we` out 1: to memory `WE`
- `mem_a` out `ADDR_W`: to memory `A`
- `mem_wd` out `DATA_W`: to memory `WD`
- `mem_rd` in `DATA_W`: from memory `RD` (combinational read)
- `owner` out 2: 2'b00 idle, 2'b01 req0, 2'b10 req1
- `busy` out 1: `owner` != 0

## Operation
- FSM states: IDLE, GNT0, GNT1. Registers: state, `rr_ptr` (1 bit, preferred requester), `beat_cnt` (4 bits).
- IDLE:
  - if exactly one `req` is high, go to that requester's GNT.
  - if both are high, go to GNT`rr_ptr`.
  - Zero accesses occur in IDLE.
- GNTx with `reqx`=1: one beat per cycle.
  - `mem_we`=`wex`, `mem_a`=`addrx`, `mem_wd`=`wdatax`, `ackx`=1, `rdatax`=`mem_rd`.
  - `beat_cnt` increments at the edge.
- GNTx with `reqx`=0: no access, `ackx`=0. Release at the edge.
- Release condition in GNTx: acked beat with `lastx`=1, or acked beat making `beat_cnt`==`BURST_MAX`, or `reqx`=0.
- On release:
  - `rr_ptr` := other requester.
  - `beat_cnt` := 0.
  - Next state is GNT(other) if the other `req` is high, else GNTx if `reqx` is high and this was not a `req`-drop release, else IDLE.
  - Handover has no bubble cycle.
- A burst cut at `BURST_MAX` is not an error. The requester keeps `req` high and resumes on its next grant.
- Non-owner outputs: `ack`=0, `rdata`=0.
- When idle: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- `mem_we` is never asserted without a matching `ack`.

## Timing
- Reset (async, `rst`=0): state IDLE, `rr_ptr`=0, `beat_cnt`=0. All outputs 0 immediately: `ack0/1`, `mem_we`, `owner`=00, `busy`=0.
- Grant latency: `req` seen at edge N while IDLE gives ownership from edge N+1. First `ack` in cycle N+1.
- Back-to-back within a grant: one beat per cycle. Write commits at the edge ending the acked cycle.
- Read data is combinational from `mem_rd` in the ack cycle. It is not registered.
- Both `req` high in IDLE: `rr_ptr` decides, then alternates after every release.
- Reset asserted mid-burst: the in-flight beat is discarded and no write commits at the next edge. After reset release, the first grant goes to req0 if both are requesting.
- `req` inputs, address and data must be stable for the whole ack cycle. The arbiter does not register them.

## Test plan
- Reset: drive `rst`=0 mid-GNT1 write burst. Expect `mem_we`=0, `owner`=00 immediately. After release, memory word unchanged by the aborted beat.
- Single read: `req0`, `we0`=0, `addr0`=5, `last0`=1, memory word 5 = 5. Expect `ack0` one cycle after `req` and `rdata0`=5, then `owner` returns to 00.
- Contention: `req0` and `req1` both rise in the same cycle, each a 2-beat write (core 0x11/0x12 to addresses 1/2, loader 0x21/0x22 to addresses 3/4). Expect GNT0 for 2 cycles, then GNT1 for 2 cycles with no bubble. Final memory words 1..4 = 0x11, 0x12, 0x21, 0x22.
- Burst cap: `req1` held with `last1`=0 for 10 beats while `req0` is continuously requesting. Expect grants to alternate in ownership runs of 4 beats, with no requester waiting more than 4 cycles.
- Request drop: GNT0 owned and `req0` falls before `last0`. Expect no `ack0` and no write that cycle. Release to GNT1 if `req1` is high, else IDLE.
- Idle: no requests for 20 cycles. Expect `mem_we`=0, `busy`=0, `rr_ptr` unchanged.
